// File: rtl/viterbi_dec_scheduler.sv
// rtl/viterbi_dec_scheduler.sv - two-channel frame scheduler sharing one Viterbi decoder
//
// Accepts 16-bit coded frames from two requesters over valid/ready. Only one
// frame is in flight at a time. The accepted frame is driven on dec_data_in
// for DEC_LAT edges. The decoded byte is then captured and presented on the
// output handshake, tagged with the channel it came from.
//
// Parameters:
//   DEC_LAT    decoder latency in edges, 1..15
//   IDLE_WORD  value on dec_data_in while no frame is in flight
//
// Ports:
//   clk, rst                    clock, async active-low reset
//   req0_valid/data/ready       channel 0 frame input
//   req1_valid/data/ready       channel 1 frame input
//   out_valid/data/ch/ready     decoded byte output plus its source channel
//   dec_data_in, dec_data_out   connection to the decoder
//   busy                        scheduler not idle
//   frame_cnt                   completed output handshakes, wrapping
//
// Build option:
//   VITERBI_SCHED_PRIO_EN  When defined, channel 0 has strict priority.
//                          Otherwise the two channels are served round-robin.

module viterbi_dec_scheduler #(
  parameter int          DEC_LAT   = 1,
  parameter logic [15:0] IDLE_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_ch,
  input  logic        out_ready,
  output logic [15:0] dec_data_in,
  input  logic [7:0]  dec_data_out,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  localparam logic [3:0] LAT = 4'(DEC_LAT);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       cur_ch;
  logic       last_ch;
  logic       grant;
  logic       accept;

  // Grant selects which channel's ready is raised in IDLE. With no requester
  // present it rests on channel 0.
  always_comb begin
    grant = 1'b0;
`ifdef VITERBI_SCHED_PRIO_EN
    if (!req0_valid && req1_valid)
      grant = 1'b1;
`else
    if (req0_valid && req1_valid)
      grant = ~last_ch;
    else if (req1_valid)
      grant = 1'b1;
`endif
  end

  assign req0_ready = (state == ST_IDLE) && !grant;
  assign req1_ready = (state == ST_IDLE) && grant;
  assign busy       = (state != ST_IDLE);
  assign accept     = grant ? (req1_valid && req1_ready) : (req0_valid && req0_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      cur_ch      <= 1'b0;
      last_ch     <= 1'b1;
      dec_data_in <= IDLE_WORD;
      out_valid   <= 1'b0;
      out_data    <= 8'h00;
      out_ch      <= 1'b0;
      frame_cnt   <= 16'h0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            dec_data_in <= grant ? req1_data : req0_data;
            cur_ch      <= grant;
            last_ch     <= grant;
            cnt         <= LAT;
            state       <= ST_RUN;
          end
        end
        ST_RUN: begin
          cnt <= cnt - 4'd1;
          // cnt==1 marks the DEC_LAT-th edge after acceptance, when the
          // decoder output for this frame is valid.
          if (cnt == 4'd1) begin
            out_data    <= dec_data_out;
            out_ch      <= cur_ch;
            out_valid   <= 1'b1;
            dec_data_in <= IDLE_WORD;
            state       <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            frame_cnt <= frame_cnt + 16'd1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_dec_scheduler.sv
// tb/tb_viterbi_dec_scheduler.sv - scoreboard bench for viterbi_dec_scheduler
//
// dut  runs with DEC_LAT=1, and dut4 runs with DEC_LAT=4. Each instance has
// a hard-decision decoder model in which byte bit i = frame bit 2i+1. The
// model is delayed so that its output is valid exactly DEC_LAT edges after
// the input changes. Expected {ch, byte} pairs are queued by the stimulus.
// A monitor per instance pops and compares them on each output handshake.

module tb_viterbi_dec_scheduler;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // instance A, DEC_LAT = 1
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [15:0] req0_data, req1_data;
  logic        out_valid, out_ch, out_ready, busy;
  logic [7:0]  out_data, dec_data_out;
  logic [15:0] dec_data_in, frame_cnt;

  // instance B, DEC_LAT = 4
  logic        b_rst;
  logic        b_req0_valid, b_req1_valid, b_req0_ready, b_req1_ready;
  logic [15:0] b_req0_data, b_req1_data;
  logic        b_out_valid, b_out_ch, b_out_ready, b_busy;
  logic [7:0]  b_out_data, b_dec_data_out;
  logic [15:0] b_dec_data_in, b_frame_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];
  logic [8:0] b_exp_q[$];

  function automatic logic [7:0] dec_f(input logic [15:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[2*i+1];
    return r;
  endfunction

  assign dec_data_out = dec_f(dec_data_in);

  logic [7:0] b_p0, b_p1, b_p2;
  always @(posedge clk) begin
    b_p0 <= dec_f(b_dec_data_in);
    b_p1 <= b_p0;
    b_p2 <= b_p1;
  end
  assign b_dec_data_out = b_p2;

  viterbi_dec_scheduler #(.DEC_LAT(1), .IDLE_WORD(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready),
    .dec_data_in(dec_data_in), .dec_data_out(dec_data_out),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  viterbi_dec_scheduler #(.DEC_LAT(4), .IDLE_WORD(16'h0000)) dut4 (
    .clk(clk), .rst(b_rst),
    .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
    .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ch(b_out_ch), .out_ready(b_out_ready),
    .dec_data_in(b_dec_data_in), .dec_data_out(b_dec_data_out),
    .busy(b_busy), .frame_cnt(b_frame_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: compare on the negedge preceding each handshake edge.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("a_unexpected_out", 1, 0);
      else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("a_out_data", {24'h0, out_data}, {24'h0, e[7:0]});
        check("a_out_ch", {31'h0, out_ch}, {31'h0, e[8]});
      end
    end
  end

  always @(negedge clk) begin
    if (b_rst && b_out_valid && b_out_ready) begin
      if (b_exp_q.size() == 0) check("b_unexpected_out", 1, 0);
      else begin
        logic [8:0] e;
        e = b_exp_q.pop_front();
        check("b_out_data", {24'h0, b_out_data}, {24'h0, e[7:0]});
        check("b_out_ch", {31'h0, b_out_ch}, {31'h0, e[8]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_a();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || out_valid) && c < 100) begin
      tick();
      c++;
    end
    check("a_drain", exp_q.size(), 0);
  endtask

  task automatic drain_b();
    int c;
    c = 0;
    while ((b_exp_q.size() != 0 || b_out_valid) && c < 100) begin
      tick();
      c++;
    end
    check("b_drain", b_exp_q.size(), 0);
  endtask

  task automatic reset_a();
    tick();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int         g[4];
    int         exp_g[4];
    int         ng;
    logic [15:0] cnt0;
    logic        stable;
    logic        seen;

    rst = 1'b0; b_rst = 1'b0;
    req0_valid = 0; req1_valid = 0; req0_data = 0; req1_data = 0; out_ready = 1;
    b_req0_valid = 0; b_req1_valid = 0; b_req0_data = 0; b_req1_data = 0; b_out_ready = 1;

    // reset state
    tick();
    check("rst_out_valid", {31'h0, out_valid}, 0);
    check("rst_out_data", {24'h0, out_data}, 0);
    check("rst_out_ch", {31'h0, out_ch}, 0);
    check("rst_dec_in", {16'h0, dec_data_in}, 0);
    check("rst_frame_cnt", {16'h0, frame_cnt}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    rst = 1'b1; b_rst = 1'b1;

    // single frame
    tick();
    req0_valid = 1; req0_data = 16'hFFFF;
    exp_q.push_back({1'b0, 8'hFF});
    #1;
    check("sf_req0_ready", {31'h0, req0_ready}, 1);
    check("sf_req1_ready", {31'h0, req1_ready}, 0);
    tick();
    req0_valid = 0;
    check("sf_ready_drop", {31'h0, req0_ready}, 0);
    check("sf_dec_in", {16'h0, dec_data_in}, 32'hFFFF);
    check("sf_busy", {31'h0, busy}, 1);
    tick();
    check("sf_out_valid", {31'h0, out_valid}, 1);
    check("sf_dec_idle", {16'h0, dec_data_in}, 0);
    tick();
    check("sf_frame_cnt", {16'h0, frame_cnt}, 1);
    check("sf_valid_drop", {31'h0, out_valid}, 0);

    // contention
    reset_a();
`ifdef VITERBI_SCHED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 4; i++)
      exp_q.push_back({exp_g[i] == 1, (exp_g[i] == 1) ? 8'h00 : 8'hFF});
    req0_data = 16'hAAAA; req1_data = 16'h5555;
    req0_valid = 1; req1_valid = 1;
    ng = 0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) begin g[ng] = 0; ng++; end
      else if (req1_valid && req1_ready) begin g[ng] = 1; ng++; end
    end
    tick();
    req0_valid = 0; req1_valid = 0;
    check("rr_grant_count", ng, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("rr_grant%0d", i), g[i], exp_g[i]);
    drain_a();

    // back-pressure
    cnt0 = frame_cnt;
    out_ready = 0;
    req0_valid = 1; req0_data = 16'hC3C3;
    exp_q.push_back({1'b0, 8'h99});
    tick();
    req0_valid = 0;
    req1_valid = 1; req1_data = 16'h5555;
    exp_q.push_back({1'b1, 8'h00});
    tick();
    check("bp_out_valid", {31'h0, out_valid}, 1);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!out_valid || out_data !== 8'h99 || req1_ready) stable = 1'b0;
    end
    check("bp_stable", {31'h0, stable}, 1);
    check("bp_cnt_hold", {16'h0, frame_cnt}, {16'h0, cnt0});
    out_ready = 1;
    tick();
    check("bp_cnt_inc", {16'h0, frame_cnt}, {16'h0, 16'(cnt0 + 16'd1)});
    check("bp_valid_drop", {31'h0, out_valid}, 0);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (req1_ready) seen = 1'b1;
    end
    check("bp_req1_grant", {31'h0, seen}, 1);
    tick();
    req1_valid = 0;
    drain_a();

    // latency sweep on DEC_LAT=4
    b_req0_valid = 1; b_req0_data = 16'h1234;
    b_exp_q.push_back({1'b0, 8'h14});
    tick();
    b_req0_valid = 0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("lat_dec_in%0d", i), {16'h0, b_dec_data_in}, 32'h1234);
      check($sformatf("lat_no_valid%0d", i), {31'h0, b_out_valid}, 0);
      tick();
    end
    check("lat_valid", {31'h0, b_out_valid}, 1);
    check("lat_dec_idle", {16'h0, b_dec_data_in}, 0);
    drain_b();

    // reset mid-RUN on DEC_LAT=4
    b_req0_valid = 1; b_req0_data = 16'hFFFF;
    tick();
    b_req0_valid = 0;
    tick();
    tick();
    check("rm_busy", {31'h0, b_busy}, 1);
    b_rst = 1'b0;
    #1;
    check("rm_busy_clr", {31'h0, b_busy}, 0);
    check("rm_dec_in", {16'h0, b_dec_data_in}, 0);
    check("rm_out_valid", {31'h0, b_out_valid}, 0);
    check("rm_out_data", {24'h0, b_out_data}, 0);
    tick();
    tick();
    b_rst = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (b_out_valid) stable = 1'b0;
    end
    check("rm_no_output", {31'h0, stable}, 1);
    b_req0_valid = 1; b_req0_data = 16'hAAAA;
    b_req1_valid = 1; b_req1_data = 16'h5555;
    b_exp_q.push_back({1'b0, 8'hFF});
    @(negedge clk);
    check("rm_grant0", {31'h0, b_req0_ready}, 1);
    check("rm_not1", {31'h0, b_req1_ready}, 0);
    tick();
    b_req0_valid = 0; b_req1_valid = 0;
    drain_b();

    // frame counter wrap
    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    check("wrap_preload", {16'h0, frame_cnt}, 32'hFFFF);
    tick();
    req0_valid = 1; req0_data = 16'h5555;
    exp_q.push_back({1'b0, 8'h00});
    tick();
    req0_valid = 0;
    drain_a();
    check("wrap_zero", {16'h0, frame_cnt}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/viterbi_dec_scheduler.md
# viterbi_dec_scheduler

Two-channel frame scheduler that shares a single `viterbi_decoder_top` instance between two requesters. It accepts 16-bit coded frames (8 symbol pairs) from either channel over valid/ready, arbitrates round-robin, and drives the decoder input for a fixed latency. It then captures the 8-bit decoded byte and returns it tagged with its source channel. It sits directly between the demux of the two receive paths and the decoder.

## Interface
- `DEC_LAT`, 1: decoder latency in clock edges from a `data_in` change to a valid `data_out`; legal range 1..15.
- `IDLE_WORD`, 16'h0000: value driven on `dec_data_in` when no frame is in flight.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: channel 0 frame present.
- `req0_data` in 16: channel 0 coded frame.
- `req0_ready` out 1: channel 0 frame accepted this edge if valid.
- `req1_valid`, `req1_data`, `req1_ready`: same as channel 0, for channel 1.
- `out_valid` out 1: decoded byte available.
- `out_data` out 8: decoded byte.
- `out_ch` out 1: source channel of `out_data`.
- `out_ready` in 1: consumer accepts the byte.
- `dec_data_in` out 16: to decoder `data_in`.
- `dec_data_out` in 8: from decoder `data_out`.
- `busy` out 1: state is not IDLE.
- `frame_cnt` out 16: count of completed output handshakes; wraps from 16'hFFFF to 0.

## Operation
- FSM states: IDLE, RUN, OUT.
- **IDLE**
  - `grant` is computed combinationally.
    - Only one valid: that channel.
    - Both valid: the channel not equal to `last_ch`.
  - `reqN_ready` = (state==IDLE) && grant==N. Both ready signals are never high together.
  - On `reqN_valid && reqN_ready`:
    - `dec_data_in` <= `reqN_data`.
    - `cur_ch` <= N; `last_ch` <= N.
    - `cnt` <= DEC_LAT.
    - State goes to RUN.
- **RUN**
  - All `reqN_ready` are low.
  - `cnt` decrements every edge.
  - On the edge where `cnt`==1 before the decrement, i.e. the DEC_LAT-th edge after acceptance:
    - `out_data` <= `dec_data_out`.
    - `out_ch` <= `cur_ch`.
    - `out_valid` <= 1.
    - `dec_data_in` <= IDLE_WORD.
    - State goes to OUT.
- **OUT**
  - `out_valid`, `out_data` and `out_ch` hold stable until `out_ready`.
  - On `out_valid && out_ready`:
    - `out_valid` <= 0.
    - `frame_cnt` increments.
    - State goes to IDLE.
- `cnt` is 4 bits and only decrements in RUN. It never underflows because the RUN exit happens at 1.
- Requester data is sampled only on the accept edge. Later changes on `reqN_data` do not affect an in-flight frame.

## Timing
- All outputs are registered except `reqN_ready` and `busy`, which decode the state.
- Reset values: state=IDLE, `dec_data_in`=IDLE_WORD, `out_valid`=0, `out_data`=0, `out_ch`=0, `frame_cnt`=0, `cnt`=0.
  - `last_ch` resets to 1, so channel 0 wins the first contention.
- Reset assertion is immediate and asynchronous. An in-flight frame is dropped and no `out_valid` is produced for it.
- Latency:
  - Accept edge E0.
  - `dec_data_in` is valid after E0.
  - `out_valid` is high after edge E0+DEC_LAT.
- Minimum frame period is DEC_LAT+2 cycles: DEC_LAT in RUN, 1 in OUT with `out_ready` already high, 1 in IDLE.
- Back-pressure: `out_ready` low stalls in OUT indefinitely. No new frame is accepted while stalled.
- A `reqN_valid` deasserted in IDLE before ready is simply not granted. There is no state effect.

## Configuration
- `VITERBI_SCHED_PRIO_EN`
  - Defined: strict priority. Channel 0 is always granted when `req0_valid` is high; `last_ch` is still updated but ignored.
  - Undefined (default): round-robin as described above.

## Test plan
- **Single frame:** reset, then `req0_valid`=1 with `req0_data`=16'hFFFF, `out_ready`=1, decoder model returning 8'hFF at DEC_LAT=1.
  - `req0_ready` high one cycle.
  - `dec_data_in`=16'hFFFF for exactly 1 cycle.
  - `out_valid` with `out_data`=8'hFF, `out_ch`=0; `frame_cnt`=1.
- **Contention round-robin:** both channels valid continuously (16'hAAAA, 16'h5555).
  - Grants alternate 0,1,0,1.
  - `out_ch` sequence is 0,1,0,1.
  - With `VITERBI_SCHED_PRIO_EN`, all four grants go to channel 0.
- **Back-pressure:** `out_ready`=0 for 10 cycles after `out_valid`.
  - `out_data` stays stable.
  - `req1_ready` stays low throughout.
  - Completion occurs on the edge `out_ready` rises; `frame_cnt` increments once.
- **Latency sweep:** DEC_LAT=4, frame 16'h1234.
  - `dec_data_in` holds 16'h1234 for 4 cycles.
  - `out_valid` rises exactly 4 edges after accept.
  - `dec_data_in` returns to IDLE_WORD.
- **Reset mid-RUN:** assert `rst` low 2 cycles after accept.
  - All outputs return to reset values immediately.
  - No `out_valid` after release.
  - Next contention is granted to channel 0.
- **Counter wrap:** force `frame_cnt`=16'hFFFF via 65535 frames, or hierarchical preload, then complete one frame.
  - `frame_cnt`=0.
